alu_seq_core: RTL and testbench

- 64-bit arithmetic/logic execution core that produces the 128-bit result word consumed directly by the 128-bit output register stage.
- Single-cycle operations: add, subtract, AND, OR, XOR.
- Multi-cycle operations: 64-iteration shift-add multiply and restoring divide.
- Uses a start/busy/done handshake, so the upstream operand source and the downstream register know when `result` is valid.

---
 rtl/alu_seq_core.sv | 171 +++++++++++++++++
 tb/tb_alu_seq_core.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// 64-bit ALU core: single-cycle add/sub/logic, 64-iteration shift-add multiply and restoring divide.
// Optional divider datapath is enabled by defining ALU_DIV_EN; otherwise opcode 110 acts as reserved.
module alu_seq_core #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               err
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;

    typedef enum logic {IDLE, CALC} state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;
    logic [WIDTH:0]     sum;
    logic               accept;
    logic               multi;
    logic               last;

`ifdef ALU_DIV_EN
    logic               is_div;
    logic [WIDTH:0]     shifted;
    logic               fits;

    assign multi = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
`else
    assign multi = (op == OP_MUL);
`endif

    assign busy   = (state == CALC);
    assign accept = (state == IDLE) && start;
    assign last   = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));

    // {hi, lo} is a shared shift pair: product for MUL, {remainder, quotient} for DIV
    always_comb begin
        sum     = {1'b0, hi} + {1'b0, (lo[0] ? opnd : '0)};
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        shifted = {hi, lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, opnd});
        if (is_div) begin
            hi_next = fits ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], fits};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && multi) next_state = CALC;
            CALC:    if (last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
`ifdef ALU_DIV_EN
            is_div <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                err <= 1'b0;
                case (op)
                    OP_ADD: begin
                        result <= {{(WIDTH-1){1'b0}}, {1'b0, a} + {1'b0, b}};
                        done   <= 1'b1;
                    end
                    OP_SUB: begin
                        result <= {{(WIDTH-1){1'b0}}, (a < b), a - b};
                        done   <= 1'b1;
                    end
                    OP_AND: begin
                        result <= {{WIDTH{1'b0}}, a & b};
                        done   <= 1'b1;
                    end
                    OP_OR: begin
                        result <= {{WIDTH{1'b0}}, a | b};
                        done   <= 1'b1;
                    end
                    OP_XOR: begin
                        result <= {{WIDTH{1'b0}}, a ^ b};
                        done   <= 1'b1;
                    end
                    OP_MUL: begin
                        opnd <= a;
                        lo   <= b;
                        hi   <= '0;
                        cnt  <= '0;
`ifdef ALU_DIV_EN
                        is_div <= 1'b0;
`endif
                    end
                    OP_DIV: begin
`ifdef ALU_DIV_EN
                        if (b == '0) begin
                            result <= {a, {WIDTH{1'b1}}};
                            err    <= 1'b1;
                            done   <= 1'b1;
                        end else begin
                            opnd   <= b;
                            lo     <= a;
                            hi     <= '0;
                            cnt    <= '0;
                            is_div <= 1'b1;
                        end
`else
                        result <= '0;
                        err    <= 1'b1;
                        done   <= 1'b1;
`endif
                    end
                    default: begin
                        result <= '0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                    end
                endcase
            end else if (state == CALC) begin
                hi  <= hi_next;
                lo  <= lo_next;
                cnt <= cnt + 1'b1;
                if (last) begin
                    result <= {hi_next, lo_next};
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core: directed cases plus randomized traffic against a
// cycle-level reference model built from plain 128-bit arithmetic.
module tb_alu_seq_core;

    localparam int WIDTH = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [2:0]         op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic               err;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic               m_busy    = 1'b0;
    logic               m_done    = 1'b0;
    logic               m_err     = 1'b0;
    logic [2*WIDTH-1:0] m_result  = '0;
    logic [2*WIDTH-1:0] m_pending = '0;
    int                 m_left    = 0;

    alu_seq_core #(.WIDTH(WIDTH), .CNT_W(7)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    function automatic bit div_enabled();
`ifdef ALU_DIV_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_multi(input logic [2:0] o, input logic [WIDTH-1:0] y);
        return (o == 3'd5) || (div_enabled() && o == 3'd6 && y != 0);
    endfunction

    function automatic bit exp_err(input logic [2:0] o, input logic [WIDTH-1:0] y);
        if (o == 3'd7) return 1'b1;
        if (o == 3'd6) return div_enabled() ? (y == 0) : 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2*WIDTH-1:0] exp_result(input logic [2:0] o,
                                                       input logic [WIDTH-1:0] x,
                                                       input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] r;
        r = '0;
        case (o)
            3'd0: r = 128'(x) + 128'(y);
            3'd1: begin
                r[WIDTH-1:0] = x - y;
                r[WIDTH]     = (x < y);
            end
            3'd2: r = 128'(x & y);
            3'd3: r = 128'(x | y);
            3'd4: r = 128'(x ^ y);
            3'd5: r = 128'(x) * 128'(y);
            3'd6: begin
                if (!div_enabled()) r = '0;
                else if (y == 0) r = {x, {WIDTH{1'b1}}};
                else r = {x % y, x / y};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Reference model: what the outputs must look like after each edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
            m_result <= '0;
            m_left   <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy   <= 1'b0;
                    m_done   <= 1'b1;
                    m_result <= m_pending;
                end
            end else if (start) begin
                m_err <= exp_err(op, b);
                if (is_multi(op, b)) begin
                    m_busy    <= 1'b1;
                    m_left    <= 64;
                    m_pending <= exp_result(op, a, b);
                end else begin
                    m_result <= exp_result(op, a, b);
                    m_done   <= 1'b1;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [2*WIDTH-1:0] act,
                                input logic [2*WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output("busy", 128'(busy), 128'(m_busy));
            check_output("done", 128'(done), 128'(m_done));
            check_output("result", result, m_result);
            check_output("err", 128'(err), 128'(m_err));
        end
    end

    task automatic apply_stimulus(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
    endtask

    // Latency counts negedges from the first one after the accepting edge (single-cycle = 1)
    task automatic wait_done(output int lat, output int busy_cycles);
        lat         = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_case(input string name, input logic [2:0] o, input logic [WIDTH-1:0] x,
                            input logic [WIDTH-1:0] y, input int exp_lat, input int exp_busy,
                            input logic [2*WIDTH-1:0] exp_res, input logic exp_e);
        int lat;
        int bc;
        apply_stimulus(o, x, y);
        wait_done(lat, bc);
        check_output({name, "_latency"}, 128'(lat), 128'(exp_lat));
        check_output({name, "_busy_cycles"}, 128'(bc), 128'(exp_busy));
        check_output({name, "_result"}, result, exp_res);
        check_output({name, "_err"}, 128'(err), 128'(exp_e));
    endtask

    function automatic logic [WIDTH-1:0] rand64();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return WIDTH'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int lat;
        int bc;
        int done_seen;
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check_output("reset_busy", 128'(busy), 128'(0));
        check_output("reset_done", 128'(done), 128'(0));
        check_output("reset_result", result, 128'(0));
        check_output("reset_err", 128'(err), 128'(0));
        rst      = 1'b0;
        check_en = 1'b1;

        run_case("add_carry", 3'd0, '1, 64'd1, 1, 0,
                 128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0);
        run_case("sub_borrow", 3'd1, 64'd3, 64'd5, 1, 0,
                 128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, 1'b0);
        run_case("mul_full", 3'd5, '1, '1, 65, 64,
                 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0);
`ifdef ALU_DIV_EN
        run_case("div_100_7", 3'd6, 64'd100, 64'd7, 65, 64, {64'd2, 64'd14}, 1'b0);
        run_case("div_by_zero", 3'd6, 64'd100, 64'd0, 1, 0, {64'd100, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b1);
`else
        run_case("div_disabled", 3'd6, 64'd100, 64'd7, 1, 0, 128'd0, 1'b1);
`endif
        run_case("reserved", 3'd7, 64'd9, 64'd4, 1, 0, 128'd0, 1'b1);

        // A start pulse while busy must not disturb the multiply in flight
        apply_stimulus(3'd5, 64'd3, 64'd5);
        repeat (8) @(negedge clk);
        op    = 3'd0;
        a     = 64'd1000;
        b     = 64'd2000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check_output("busy_ignore_latency", 128'(lat), 128'(56));
        check_output("busy_ignore_result", result, 128'd15);

        // Reset in the middle of a multiply clears outputs at once and suppresses done
        apply_stimulus(3'd5, {$urandom, $urandom}, {$urandom, $urandom});
        repeat (28) @(negedge clk);
        check_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_output("midrst_busy", 128'(busy), 128'(0));
        check_output("midrst_done", 128'(done), 128'(0));
        check_output("midrst_result", result, 128'(0));
        check_output("midrst_err", 128'(err), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        check_en = 1'b1;
        done_seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check_output("midrst_no_done", 128'(done_seen), 128'(0));
        run_case("add_after_rst", 3'd0, 64'd2, 64'd3, 1, 0, 128'd5, 1'b0);

        // Randomized traffic, including back-to-back starts and starts while busy
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            op    = 3'($urandom_range(0, 7));
            a     = rand64();
            b     = rand64();
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && busy === 1'b1; i++) @(negedge clk);
        check_output("final_idle", 128'(busy), 128'(0));
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
